// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned CNT_W = 8;

  typedef logic [1:0] sel_t;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output slot: a full flag plus a data register, with load/drain handshake.
module stream_demux_slot #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic [W-1:0] r_data;

  // A load wins over a drain, so a same-cycle load+drain keeps the slot full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (r_full && i_ready) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer with a one-entry slot per output.
// Optional per-output handshake counters when STREAM_DEMUX_STATS_EN is defined.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  sel_t               in_sel,
  input  logic [W-1:0]       in_data,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [N_OUT*W-1:0] out_data
`ifdef STREAM_DEMUX_STATS_EN
  ,
  output logic [N_OUT*CNT_W-1:0] out_count
`endif
);

  logic [N_OUT-1:0] w_full;
  logic [N_OUT-1:0] w_load;
  logic             w_accept;

  // The addressed slot can take a beat if it is empty or draining this cycle.
  assign in_ready = ~w_full[in_sel] | out_ready[in_sel];
  assign w_accept = in_valid & in_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign w_load[i] = w_accept && (in_sel == sel_t'(i));

    stream_demux_slot #(
      .W (W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[i]),
      .i_data  (in_data),
      .i_ready (out_ready[i]),
      .o_full  (w_full[i]),
      .o_data  (out_data[i*W +: W])
    );
  end

  assign out_valid = w_full;

`ifdef STREAM_DEMUX_STATS_EN
  for (genvar i = 0; i < N_OUT; i++) begin : g_stats
    logic [CNT_W-1:0] r_cnt;

    // Counts output handshakes; wraps naturally at 2**CNT_W.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_full[i] && out_ready[i]) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign out_count[i*CNT_W +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Scoreboard bench for stream_demux_1_4: directed stimulus, per-output expected queues.
module tb_stream_demux_1_4;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_sel;
  logic [W-1:0]   in_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] out_data;
`ifdef STREAM_DEMUX_STATS_EN
  logic [31:0]    out_count;
  logic [7:0]     cnt_m [4];
`endif

  int total = 0;
  int bad   = 0;
  int w;

  logic [W-1:0] exp_q [4][$];

  always #5 clk = ~clk;

  stream_demux_1_4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .out_count (out_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for acceptance, record it in the scoreboard.
  task automatic send(input logic [1:0] sel, input logic [W-1:0] d, output int waited);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: sel=%0d data=%0h never accepted", sel, d);
    end else begin
      exp_q[sel].push_back(d);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: pops expected beats whenever an output handshake is about to occur.
  always @(negedge clk) begin
`ifdef STREAM_DEMUX_STATS_EN
    for (int i = 0; i < 4; i++) chk($sformatf("count%0d", i), 32'(out_count[i*8 +: 8]), 32'(cnt_m[i]));
`endif
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: out%0d data=%0h with empty queue", i, out_data[i*W +: W]);
          end else begin
            chk($sformatf("out%0d_data", i), 32'(out_data[i*W +: W]), 32'(exp_q[i].pop_front()));
          end
`ifdef STREAM_DEMUX_STATS_EN
          cnt_m[i] = cnt_m[i] + 8'd1;
`endif
        end
      end
    end else begin
`ifdef STREAM_DEMUX_STATS_EN
      for (int i = 0; i < 4; i++) cnt_m[i] = 8'd0;
`endif
    end
  end

  initial begin
`ifdef STREAM_DEMUX_STATS_EN
    for (int i = 0; i < 4; i++) cnt_m[i] = 8'd0;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'hF;

    // Reset and idle
    step();
    @(negedge clk);
    chk("in_ready_during_reset", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", 32'(out_data), 32'h0);
    step();

    // Single routing with one cycle of latency
    send(2'd2, 4'hA, w);
    chk("single_wait", 32'(w), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'b0100);
    chk("single_data", 32'(out_data[11:8]), 32'hA);
    @(negedge clk);
    chk("single_valid_after", 32'(out_valid), 32'b0000);
    step();

    // Back-pressure on output 1
    out_ready = 4'b1101;
    send(2'd1, 4'h3, w);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 4'h5;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data[7:4]), 32'h3);
      chk("bp_hold_valid", 32'(out_valid[1]), 32'd1);
      step();
    end
    out_ready = 4'hF;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    exp_q[1].push_back(4'h5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid[1]), 32'd1);
    chk("bp_second_data", 32'(out_data[7:4]), 32'h5);
    step();

    // Independence: slot 1 stalled and full, others keep flowing
    out_ready = 4'b1101;
    send(2'd1, 4'h7, w);
    send(2'd0, 4'h1, w);
    chk("indep_wait0", 32'(w), 32'd0);
    send(2'd2, 4'h2, w);
    chk("indep_wait2", 32'(w), 32'd0);
    send(2'd3, 4'h3, w);
    chk("indep_wait3", 32'(w), 32'd0);
    @(negedge clk);
    chk("indep_valid", 32'(out_valid), 32'b1010);
    chk("indep_data3", 32'(out_data[15:12]), 32'h3);
    step();
    out_ready = 4'hF;
    step();
    step();

    // Throughput: 16 back-to-back beats to output 3
    in_valid = 1'b1;
    in_sel   = 2'd3;
    for (int i = 0; i < 16; i++) begin
      in_data = W'(i);
      @(negedge clk);
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk("tp_valid", 32'(out_valid[3]), 32'd1);
        chk("tp_data", 32'(out_data[15:12]), 32'(i - 1));
      end
      exp_q[3].push_back(W'(i));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("tp_last_valid", 32'(out_valid[3]), 32'd1);
    @(negedge clk);
    chk("tp_drained", 32'(out_valid[3]), 32'd0);
    step();

    // Mid-operation reset discards all buffered beats and ignores handshakes
    out_ready = 4'h0;
    send(2'd0, 4'h9, w);
    send(2'd1, 4'hA, w);
    send(2'd2, 4'hB, w);
    send(2'd3, 4'hC, w);
    @(negedge clk);
    chk("fill_all_valid", 32'(out_valid), 32'hF);
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 4'hF;
    out_ready = 4'hF;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_data", 32'(out_data), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    step();

    // 256 handshakes on output 0 wrap its counter back to zero
    for (int i = 0; i < 256; i++) begin
      send(2'd0, W'(i), w);
      if (w != 0) chk("wrap_wait", 32'(w), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("wrap_drained", 32'(out_valid), 32'h0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("wrap_count0", 32'(out_count[7:0]), 32'h0);
`endif

    for (int i = 0; i < 4; i++) chk($sformatf("queue%0d_empty", i), 32'(exp_q[i].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 The module SHALL have parameter W, default 4, giving the data width of the input stream and of each output stream.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the module accepts the input beat this cycle.
REQ-006 The module SHALL have port in_sel, input, 2 bits: destination output index 0..3 for the input beat.
REQ-007 The module SHALL have port in_data, input, W bits: input payload.
REQ-008 The module SHALL have port out_valid, output, 4 bits: bit i means output i holds a beat.
REQ-009 The module SHALL have port out_ready, input, 4 bits: bit i means the output i sink accepts a beat.
REQ-010 The module SHALL have port out_data, output, 4*W bits: the output i payload on bits [i*W +: W].

Function
REQ-011 Each output i SHALL own a one-entry slot, consisting of a full flag and a W-bit data register, with out_valid[i] = full[i] and out_data[i] = data[i].
REQ-012 in_ready SHALL be 1 when slot in_sel is empty or out_ready[in_sel] is 1, and 0 otherwise, independent of in_valid.
REQ-013 An input handshake (in_valid && in_ready) SHALL load in_data into slot in_sel and set its full flag at the next edge, giving exactly one cycle of latency from input handshake to out_valid.
REQ-014 An output handshake on i (out_valid[i] && out_ready[i]) with no load into slot i SHALL clear full[i] at the next edge.
REQ-015 A load and a drain of the same slot in the same cycle SHALL leave the slot full with the new data, sustaining 1 beat per cycle per output.
REQ-016 Slots SHALL operate independently, so a stalled output (out_ready[i]=0) blocks only beats addressed to i.
REQ-017 While out_valid[i]=1 and out_ready[i]=0, out_data[i] SHALL remain stable.
REQ-018 Upstream SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0; the module always routes using the current in_sel.
REQ-019 No beat SHALL be dropped, duplicated or reordered per destination.

Reset
REQ-020 When rst_n=0 at a rising clk edge, all full flags SHALL clear and all data registers SHALL load 0, so out_valid=4'b0000 and out_data=0.
REQ-021 in_ready SHALL be 1 during and immediately after reset, since all slots are empty.
REQ-022 A reset asserted mid-operation SHALL discard buffered beats without emitting them, and any handshake in that cycle SHALL be ignored.

Configuration
REQ-023 When the macro STREAM_DEMUX_STATS_EN is defined, the module SHALL add output port out_count, 32 bits, holding four 8-bit counters; counter i on bits [i*8 +: 8] increments on each output-i handshake, wraps from 255 to 0, and resets to 0.
REQ-024 When STREAM_DEMUX_STATS_EN is undefined, the out_count port and the counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 A package stream_demux_pkg SHALL hold the constant N_OUT=4, the typedef sel_t (logic [1:0]) and the constant CNT_W=8.
REQ-026 A sub-module stream_demux_slot, implementing one one-entry slot with load/drain handshake, SHALL be instantiated N_OUT times by stream_demux_1_4.

Verification
REQ-027 Reset and idle: hold rst_n=0 for 2 cycles, then release -> out_valid=0000, in_ready=1, out_data=0 (and out_count=0 when stats are enabled).
REQ-028 Single routing: send in_sel=2 with in_data=4'hA and out_ready=1111 -> out_valid=0100 and out_data[2]=A exactly 1 cycle later; one cycle after that, out_valid=0000.
REQ-029 Back-pressure: set out_ready[1]=0, then send beats 3 and 5 to sel=1 -> the first fills the slot, in_ready=0 while the second is held, and out_data[1] stays 3; raise out_ready[1] -> 3 then 5 are delivered in order.
REQ-030 Independence: hold out_ready=1101 with slot 1 full, then send beats to sel=0, 2 and 3 on consecutive cycles -> all are accepted with in_ready=1 and appear 1 cycle later each.
REQ-031 Throughput: send 16 consecutive beats to sel=3 with out_ready[3]=1 -> in_ready stays 1 and out_valid[3] stays 1 for 16 cycles, with data in order.
REQ-032 Mid-operation reset and stats: fill all four slots, then pulse rst_n=0 for one cycle -> out_valid=0000; with stats enabled, 256 handshakes on output 0 -> counter 0 reads 0.
